ws2812_board_driver: RTL and testbench
======================================

# ws2812_board_driver

Parametrised successor to the checkers board light controller. It snapshots the player, CPU, king and highlight bitmaps at frame start and encodes one colour per board cell. It drives a WS2812-style single-wire LED chain with a built-in bit serializer and latch gap. It adds frame handshaking, auto-refresh, per-cell blinking highlight and global brightness scaling, and sits between the CPU board-state registers and the LED strip pin.

## Interface
- NUM_CELLS, 32, board cells driven.
- LEDS_PER_CELL, 2, physical LEDs per cell.
- LIT_LED_INDEX, 1, LED within a cell that carries colour; the others send zero.
- SYS_FREQ_MHZ, 100, clock frequency.
- PERIOD_NS, 1250, bit period.
- T0H_NS, 400, high time of a 0 bit.
- T1H_NS, 800, high time of a 1 bit.
- LATCH_US, 60, low gap after a frame.
- BLINK_FRAMES, 16, frames per blink half-period.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- player_pieces  in  NUM_CELLS  cell occupied by player.
- cpu_pieces  in  NUM_CELLS  cell occupied by CPU.
- king_pieces  in  NUM_CELLS  piece is a king.
- highlight  in  NUM_CELLS  cell blinks white.
- brightness  in  3  right-shift applied to every colour byte (0 = full).
- auto_refresh  in  1  restart automatically after the latch gap.
- frame_start  in  1  single-cycle request for one frame.
- busy  out  1  high from the snapshot cycle through the end of the latch gap.
- frame_done  out  1  one-cycle pulse at the end of the latch gap.
- out  out  1  LED data line.

## Operation
- Derived constants, all rounded down:
  - BIT_CYC = PERIOD_NS*SYS_FREQ_MHZ/1000.
  - T0_CYC and T1_CYC are computed the same way from T0H_NS and T1H_NS.
  - LATCH_CYC = LATCH_US*SYS_FREQ_MHZ.
  - With defaults: BIT_CYC 125, T0_CYC 40, T1_CYC 80, LATCH_CYC 6000.
- Colour words are 24 bits in {G,R,B} order, sent MSB first.
  - BLUE = {0,0,255}
  - LIGHT_BLUE = {255,0,255}
  - RED = {0,255,0}
  - LIGHT_RED = {60,255,0}
  - WHITE = all ones
  - NONE = 0
- Cell colour priority:
  - highlight bit set and blink_phase=1 → WHITE.
  - else player → king ? LIGHT_BLUE : BLUE.
  - else cpu → king ? LIGHT_RED : RED.
  - else NONE.
- Brightness: each byte is shifted right by brightness before transmission.
- Chain order: LED 0 is sent first. LED k belongs to cell k/LEDS_PER_CELL. It is lit iff k%LEDS_PER_CELL == LIT_LED_INDEX; otherwise it sends NONE.
- State machine:
  - IDLE: out=0. When frame_start or pending is set, snapshot all bitmaps and brightness into registers, clear pending, and go to SEND.
  - SEND: per bit, out=1 while bit_cnt < (bit ? T1_CYC : T0_CYC), else 0. bit_cnt wraps at BIT_CYC−1, then the bit index advances. After bit 0 of the last LED, go to LATCH.
  - LATCH: out=0 for LATCH_CYC cycles, then pulse frame_done.
    - Next state is IDLE, unless auto_refresh=1 or pending=1. In that case, snapshot immediately and go to SEND with no IDLE cycle.
- Input coherence: inputs are only sampled at the snapshot. Changes during SEND/LATCH affect the next frame only.
- pending flag: set by frame_start while busy=1. Multiple requests collapse to one. Cleared on snapshot.
- blink_phase: frame counter that toggles blink_phase each BLINK_FRAMES completed frames. The phase is captured with the snapshot.
- Reset (reset=0 at clk edge):
  - state=IDLE
  - out=0, busy=0, frame_done=0
  - pending=0, blink_phase=0, frame counter=0
  - This applies mid-frame too; the partial frame is abandoned and the line stays low.

## Timing
- frame_start high at edge N → busy=1 and snapshot at N+1 → first out=1 at N+1.
- Frame duration from first high: NUM_CELLS*LEDS_PER_CELL*24*BIT_CYC + LATCH_CYC cycles. With defaults this is 192000 + 6000.
- frame_done is asserted on the last LATCH cycle.
  - busy falls on the next cycle, unless the driver restarts.
  - On restart, busy stays high continuously and the next frame's first high is the cycle after frame_done.
- out is registered; there is no combinational path from inputs to out.
- frame_start asserted in the same cycle as frame_done sets pending, and the next frame follows immediately.

## Test plan
- Reset then idle: out, busy and frame_done stay 0 for 1000 cycles with no request.
- Single frame, player_pieces=1, others 0, brightness 0:
  - LEDs 0, 2..63 send 24 zero bits, each 40 high / 85 low.
  - LED1 sends 0x0000FF: 16 short bits then 8 long bits (80 high).
  - frame_done fires after 198000 cycles.
- King and priority: cell 5 set in both player_pieces and cpu_pieces, king_pieces[5]=1 → LED 11 sends 0xFF00FF. cpu-only king → 0x3CFF00.
- Brightness=2 with cpu cell 0 → 0x003F00. Changing inputs mid-frame leaves the current frame unchanged; the change appears in the next frame.
- Two frame_start pulses while busy → exactly one extra frame, back-to-back.
- auto_refresh=1 with highlight[0]=1 → LED1 alternates NONE/WHITE every 16 frames.
- Reset asserted mid-SEND → out=0 and busy=0 on the next edge.

Source files
------------

// File: rtl/ws2812_board_driver.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_board_driver
// Description : Snapshots the checkers board bitmaps at frame start, encodes
//               one {G,R,B} colour per cell and serialises it onto a
//               WS2812-style single-wire LED chain, followed by a latch gap.
//               Adds frame handshake, auto-refresh, blinking highlight and
//               global brightness scaling.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_board_driver #(
    parameter int NUM_CELLS     = 32,
    parameter int LEDS_PER_CELL = 2,
    parameter int LIT_LED_INDEX = 1,
    parameter int SYS_FREQ_MHZ  = 100,
    parameter int PERIOD_NS     = 1250,
    parameter int T0H_NS        = 400,
    parameter int T1H_NS        = 800,
    parameter int LATCH_US      = 60,
    parameter int BLINK_FRAMES  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CELLS-1:0] player_pieces,
    input  logic [NUM_CELLS-1:0] cpu_pieces,
    input  logic [NUM_CELLS-1:0] king_pieces,
    input  logic [NUM_CELLS-1:0] highlight,
    input  logic [2:0]           brightness,
    input  logic                 auto_refresh,
    input  logic                 frame_start,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 out
);

    // Cycle counts derived from the clock frequency (all rounded down)
    localparam int c_BIT_CYC   = PERIOD_NS * SYS_FREQ_MHZ / 1000;
    localparam int c_T0_CYC    = T0H_NS * SYS_FREQ_MHZ / 1000;
    localparam int c_T1_CYC    = T1H_NS * SYS_FREQ_MHZ / 1000;
    localparam int c_LATCH_CYC = LATCH_US * SYS_FREQ_MHZ;

    localparam int c_BIT_W   = $clog2(c_BIT_CYC + 1);
    localparam int c_LATCH_W = $clog2(c_LATCH_CYC + 1);
    localparam int c_FRM_W   = $clog2(BLINK_FRAMES + 1);
    localparam int c_CELL_W  = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam int c_SUB_W   = (LEDS_PER_CELL > 1) ? $clog2(LEDS_PER_CELL) : 1;

    localparam logic [c_BIT_W-1:0]   c_BIT_LAST   = c_BIT_W'(c_BIT_CYC - 1);
    localparam logic [c_BIT_W-1:0]   c_T0         = c_BIT_W'(c_T0_CYC);
    localparam logic [c_BIT_W-1:0]   c_T1         = c_BIT_W'(c_T1_CYC);
    localparam logic [c_LATCH_W-1:0] c_LATCH_LAST = c_LATCH_W'(c_LATCH_CYC - 1);
    localparam logic [c_FRM_W-1:0]   c_FRM_LAST   = c_FRM_W'(BLINK_FRAMES - 1);
    localparam logic [c_CELL_W-1:0]  c_CELL_LAST  = c_CELL_W'(NUM_CELLS - 1);
    localparam logic [c_SUB_W-1:0]   c_SUB_LAST   = c_SUB_W'(LEDS_PER_CELL - 1);
    localparam logic [c_SUB_W-1:0]   c_SUB_LIT    = c_SUB_W'(LIT_LED_INDEX);
    localparam logic [4:0]           c_MSB_IDX    = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Frame snapshot
    logic [NUM_CELLS-1:0] r_player;
    logic [NUM_CELLS-1:0] r_cpu;
    logic [NUM_CELLS-1:0] r_king;
    logic [NUM_CELLS-1:0] r_hl;
    logic [2:0]           r_bright;
    logic                 r_snap_phase;

    // Serializer position
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [4:0]           r_bit_idx;
    logic [c_CELL_W-1:0]  r_cell;
    logic [c_SUB_W-1:0]   r_sub;
    logic [c_LATCH_W-1:0] r_latch_cnt;
    logic                 r_out;

    // Request and blink bookkeeping
    logic                 r_pending;
    logic                 r_blink_phase;
    logic [c_FRM_W-1:0]   r_frm_cnt;

    logic                 w_snap;
    logic                 w_bit_end;
    logic                 w_frame_end;
    logic                 w_latch_end;
    logic                 w_req;
    logic                 w_phase_nxt;
    logic [c_BIT_W-1:0]   w_cnt_inc;
    logic [c_BIT_W-1:0]   w_hi_len;
    logic                 w_cur_bit;
    logic [7:0]           w_g;
    logic [7:0]           w_r;
    logic [7:0]           w_b;
    logic [23:0]          w_word;

    assign w_bit_end   = (r_bit_cnt == c_BIT_LAST);
    assign w_frame_end = w_bit_end && (r_bit_idx == 5'd0) &&
                         (r_cell == c_CELL_LAST) && (r_sub == c_SUB_LAST);
    assign w_latch_end = (r_state == ST_LATCH) && (r_latch_cnt == c_LATCH_LAST);
    // A request arriving on the last latch cycle counts as pending already
    assign w_req       = r_pending || frame_start;
    // Phase after counting the frame that may be completing this cycle
    assign w_phase_nxt = (w_latch_end && (r_frm_cnt == c_FRM_LAST)) ?
                         ~r_blink_phase : r_blink_phase;
    assign w_cnt_inc   = r_bit_cnt + 1'b1;
    assign out         = r_out;

    // Colour of the LED currently being shifted out, brightness applied per byte
    always_comb begin
        w_g = 8'h00;
        w_r = 8'h00;
        w_b = 8'h00;
        if (r_sub == c_SUB_LIT) begin
            if (r_hl[r_cell] && r_snap_phase) begin
                w_g = 8'hFF; w_r = 8'hFF; w_b = 8'hFF;
            end else if (r_player[r_cell]) begin
                w_g = r_king[r_cell] ? 8'hFF : 8'h00;
                w_b = 8'hFF;
            end else if (r_cpu[r_cell]) begin
                w_g = r_king[r_cell] ? 8'h3C : 8'h00;
                w_r = 8'hFF;
            end
        end
        w_word    = {w_g >> r_bright, w_r >> r_bright, w_b >> r_bright};
        w_cur_bit = w_word[r_bit_idx];
        w_hi_len  = w_cur_bit ? c_T1 : c_T0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, snapshot strobe and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_snap      = 1'b0;
        busy        = (r_state != ST_IDLE);
        frame_done  = w_latch_end;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_snap      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_frame_end) begin
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (w_latch_end) begin
                    if (auto_refresh || w_req) begin
                        w_snap      = 1'b1;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Snapshot, serializer counters, registered data line and request/blink tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_player      <= '0;
            r_cpu         <= '0;
            r_king        <= '0;
            r_hl          <= '0;
            r_bright      <= 3'd0;
            r_snap_phase  <= 1'b0;
            r_bit_cnt     <= '0;
            r_bit_idx     <= c_MSB_IDX;
            r_cell        <= '0;
            r_sub         <= '0;
            r_latch_cnt   <= '0;
            r_out         <= 1'b0;
            r_pending     <= 1'b0;
            r_blink_phase <= 1'b0;
            r_frm_cnt     <= '0;
        end else begin
            if (w_snap) begin
                r_pending <= 1'b0;
            end else if (frame_start && busy) begin
                r_pending <= 1'b1;
            end

            if (w_latch_end) begin
                r_blink_phase <= w_phase_nxt;
                r_frm_cnt     <= (r_frm_cnt == c_FRM_LAST) ? '0 : r_frm_cnt + 1'b1;
            end

            if (w_snap) begin
                r_player     <= player_pieces;
                r_cpu        <= cpu_pieces;
                r_king       <= king_pieces;
                r_hl         <= highlight;
                r_bright     <= brightness;
                r_snap_phase <= w_phase_nxt;
                r_bit_cnt    <= '0;
                r_bit_idx    <= c_MSB_IDX;
                r_cell       <= '0;
                r_sub        <= '0;
                // Every bit starts high, so the first cycle needs no colour lookup
                r_out        <= 1'b1;
            end else if (r_state == ST_SEND) begin
                if (w_bit_end) begin
                    r_bit_cnt <= '0;
                    if (w_frame_end) begin
                        r_out       <= 1'b0;
                        r_latch_cnt <= '0;
                    end else begin
                        r_out <= 1'b1;
                        if (r_bit_idx == 5'd0) begin
                            r_bit_idx <= c_MSB_IDX;
                            if (r_sub == c_SUB_LAST) begin
                                r_sub  <= '0;
                                r_cell <= r_cell + 1'b1;
                            end else begin
                                r_sub <= r_sub + 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx - 1'b1;
                        end
                    end
                end else begin
                    r_bit_cnt <= w_cnt_inc;
                    r_out     <= (w_cnt_inc < w_hi_len);
                end
            end else if (r_state == ST_LATCH) begin
                r_out       <= 1'b0;
                r_latch_cnt <= r_latch_cnt + 1'b1;
            end else begin
                r_out <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_board_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812_board_driver
// Description : Scoreboard bench for ws2812_board_driver. Stimulus pushes the
//               hand-computed LED words of each frame into a queue; a monitor
//               decodes the data line and compares every received word.
//               Scaled-down parameters keep one frame at 2896 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_board_driver;

    localparam int NC    = 6;
    localparam int BLINK = 2;
    localparam int BIT   = 10;   // 1250 ns * 8 MHz
    localparam int T0    = 3;    // 400 ns * 8 MHz, rounded down
    localparam int T1    = 6;    // 800 ns * 8 MHz, rounded down
    localparam int LATCH = 16;   // 2 us * 8 MHz
    localparam int NLED  = 12;
    localparam int FRAME = NLED * 24 * BIT + LATCH;

    typedef logic [23:0] frame_t [NLED];

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] player_pieces, cpu_pieces, king_pieces, highlight;
    logic [2:0]    brightness;
    logic          auto_refresh, frame_start;
    logic          busy, frame_done, out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] exp_q[$];

    int cyc = 0;
    int frames_done = 0;
    int b2b = 0;

    ws2812_board_driver #(
        .NUM_CELLS(NC), .LEDS_PER_CELL(2), .LIT_LED_INDEX(1),
        .SYS_FREQ_MHZ(8), .PERIOD_NS(1250), .T0H_NS(400), .T1H_NS(800),
        .LATCH_US(2), .BLINK_FRAMES(BLINK)
    ) dut (
        .clk(clk), .reset(reset),
        .player_pieces(player_pieces), .cpu_pieces(cpu_pieces),
        .king_pieces(king_pieces), .highlight(highlight),
        .brightness(brightness), .auto_refresh(auto_refresh),
        .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
        .out(out)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic push_frame(input frame_t f);
        for (int i = 0; i < NLED; i++) exp_q.push_back(f[i]);
    endtask

    task automatic pulse_start();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int budget;
        budget = (target - frames_done) * FRAME + 200;
        while (frames_done < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (frames_done < target) check("frame_wait_timeout", frames_done, target);
    endtask

    // Monitor: decode bits from the line, assemble words, score against the queue
    initial begin
        bit          inbit, lowseen, glitch;
        int          hcnt, pcnt, nbits, words, first, last_done;
        logic [23:0] word;
        inbit = 0; nbits = 0; words = 0; first = 0; last_done = -10; word = '0;
        hcnt = 0; pcnt = 0; lowseen = 0; glitch = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                inbit = 0; nbits = 0; words = 0;
            end else begin
                if (frame_done) begin
                    frames_done++;
                    check("frame_length", cyc - first, FRAME - 1);
                    check("words_per_frame", words, NLED);
                    check("busy_at_done", busy, 1);
                    words = 0;
                    last_done = cyc;
                end
                if (!inbit) begin
                    if (out) begin
                        if (nbits == 0 && words == 0) begin
                            first = cyc;
                            if (cyc == last_done + 1) b2b++;
                        end
                        inbit = 1; hcnt = 1; pcnt = 1; lowseen = 0; glitch = 0;
                    end
                end else begin
                    pcnt++;
                    if (out) begin
                        if (lowseen) glitch = 1;
                        else hcnt++;
                    end else begin
                        lowseen = 1;
                    end
                    if (pcnt == BIT) begin
                        inbit = 0;
                        check("bit_high_cycles", glitch ? 99 : hcnt,
                              (hcnt >= (T0 + T1) / 2) ? T1 : T0);
                        word = {word[22:0], (hcnt >= (T0 + T1) / 2) ? 1'b1 : 1'b0};
                        nbits++;
                        if (nbits == 24) begin
                            nbits = 0;
                            if (exp_q.size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL unexpected_word: got %06h expected none", word);
                            end else begin
                                check($sformatf("led%0d_word", words), word, exp_q.pop_front());
                            end
                            words++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        frame_t frm;
        bit     bad;
        int     b2b0, guard;
        reset = 1'b0; frame_start = 1'b0; auto_refresh = 1'b0; brightness = 3'd0;
        player_pieces = '0; cpu_pieces = '0; king_pieces = '0; highlight = '0;
        repeat (5) @(negedge clk);
        check("reset_out", out, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        reset = 1'b1;

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (out || busy || frame_done) bad = 1;
        end
        check("idle_quiet", bad, 0);

        // Frame 0: single player piece in cell 0 -> LED1 blue
        frm = '{default: 24'h0}; frm[1] = 24'h0000FF; push_frame(frm);
        player_pieces = 6'b000001;
        pulse_start();
        check("start_busy", busy, 1);
        check("start_out", out, 1);
        wait_frames(1);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("out_after_done", out, 0);

        // Frame 1: kings and priority
        player_pieces = 6'b100010; cpu_pieces = 6'b101100; king_pieces = 6'b100100;
        frm = '{default: 24'h0};
        frm[3] = 24'h0000FF; frm[5] = 24'h3CFF00; frm[7] = 24'h00FF00; frm[11] = 24'hFF00FF;
        push_frame(frm);
        pulse_start();
        wait_frames(2);

        // Frame 2: brightness 2 on a cpu cell; inputs change mid-frame
        player_pieces = '0; cpu_pieces = 6'b000001; king_pieces = '0; brightness = 3'd2;
        frm = '{default: 24'h0}; frm[1] = 24'h003F00; push_frame(frm);
        b2b0 = b2b;
        pulse_start();
        repeat (500) @(negedge clk);
        player_pieces = 6'b111111; cpu_pieces = '0; brightness = 3'd1;
        // Frame 3: two requests while busy collapse into one back-to-back frame
        frm = '{default: 24'h0};
        for (int i = 1; i < NLED; i += 2) frm[i] = 24'h00007F;
        push_frame(frm);
        pulse_start();
        repeat (100) @(negedge clk);
        pulse_start();
        wait_frames(4);
        check("pending_back_to_back", b2b - b2b0, 1);
        repeat (FRAME + 200) @(negedge clk);
        check("no_extra_frame", frames_done, 4);
        check("idle_after_pending", busy, 0);

        // Frames 4..9: auto-refresh with blinking highlight on cell 0
        player_pieces = '0; cpu_pieces = '0; king_pieces = '0; brightness = 3'd0;
        highlight = 6'b000001;
        for (int i = 0; i < 6; i++) begin
            frm = '{default: 24'h0};
            frm[1] = (i == 2 || i == 3) ? 24'hFFFFFF : 24'h000000;
            push_frame(frm);
        end
        b2b0 = b2b;
        auto_refresh = 1'b1;
        pulse_start();
        wait_frames(9);
        @(posedge clk);
        @(negedge clk) auto_refresh = 1'b0;
        wait_frames(10);
        check("auto_back_to_back", b2b - b2b0, 5);

        // Frame 10 (blink phase 1) aborted by reset while the line is high
        frm = '{default: 24'h0}; frm[1] = 24'hFFFFFF; push_frame(frm);
        pulse_start();
        repeat (300) @(negedge clk);
        guard = 0;
        while (!out && guard < 2 * BIT) begin
            @(negedge clk);
            guard++;
        end
        check("line_high_before_abort", out, 1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_out", out, 0);
        check("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("abort_out_held", out, 0);
        exp_q.delete();
        reset = 1'b1;

        // After reset the blink counter restarts: highlight shows NONE again
        frm = '{default: 24'h0}; push_frame(frm);
        pulse_start();
        wait_frames(11);
        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("frames_total", frames_done, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
